// File: rtl/oam_dma_arbiter_pkg.sv
// Shared Game Boy bus definitions: OAM DMA register map, transfer geometry and
// the sequencer state encoding used by the arbiter and its sequencer.
package oam_dma_arbiter_pkg;

    localparam logic [15:0] DMA_REG_DEFAULT  = 16'hFF46;
    localparam logic [15:0] DMA_DEST_DEFAULT = 16'hFE00;
    localparam int          DMA_LEN_DEFAULT  = 160;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RD    = 2'd2;
    localparam logic [1:0] ST_WR    = 2'd3;

    typedef struct packed {
        logic [15:0] address;
        logic [7:0]  wdata;
        logic        nread;
        logic        nwrite;
    } bus_req_t;

    localparam bus_req_t BUS_IDLE = '{address: 16'h0000, wdata: 8'h00, nread: 1'b1, nwrite: 1'b1};

    function automatic logic owns_bus(input logic [1:0] state);
        return state != ST_IDLE;
    endfunction

endpackage

// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: copies DMA_LEN bytes from {src_hi, idx} to DMA_DEST+idx,
// one read cycle and one write cycle per byte.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | bus belongs to the core
// ST_START | one idle bus cycle after a trigger
// ST_RD    | read source byte {src_hi, idx} into data_q
// ST_WR    | write data_q to DMA_DEST+idx, advance or finish
module oam_dma_seq
    import oam_dma_arbiter_pkg::*;
#(
    parameter logic [15:0] DMA_DEST = DMA_DEST_DEFAULT,
    parameter int          DMA_LEN  = DMA_LEN_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [7:0] trigger_data,
    input  logic [7:0] bus_rdata,
    output logic       dma_active,
    output logic [7:0] src_hi,
    output bus_req_t   dma_req
);

    localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

    logic [1:0] state;
    logic [7:0] idx;
    logic [7:0] data_q;

    // A trigger outranks every state transition, including the final write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            idx    <= 8'h00;
            src_hi <= 8'h00;
            data_q <= 8'h00;
        end else if (trigger) begin
            state  <= ST_START;
            idx    <= 8'h00;
            src_hi <= trigger_data;
        end else begin
            case (state)
                ST_START: state <= ST_RD;
                ST_RD: begin
                    data_q <= bus_rdata;
                    state  <= ST_WR;
                end
                ST_WR: begin
                    if (idx == IDX_LAST) begin
                        state <= ST_IDLE;
                        idx   <= 8'h00;
                    end else begin
                        state <= ST_RD;
                        idx   <= idx + 8'h01;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dma_req       = BUS_IDLE;
        dma_req.wdata = data_q;
        case (state)
            ST_RD: begin
                dma_req.address = {src_hi, idx};
                dma_req.nread   = 1'b0;
            end
            ST_WR: begin
                dma_req.address = DMA_DEST + {8'h00, idx};
                dma_req.nwrite  = 1'b0;
            end
            default: ;
        endcase
    end

    assign dma_active = owns_bus(state);

endmodule

// File: rtl/oam_dma_arbiter.sv
// Core/DMA bus arbiter: passes the core straight through while idle, intercepts
// the DMA trigger register, and stalls the core while the sequencer owns the bus.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter logic [15:0] DMA_REG  = DMA_REG_DEFAULT,
    parameter logic [15:0] DMA_DEST = DMA_DEST_DEFAULT,
    parameter int          DMA_LEN  = DMA_LEN_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] core_address,
    input  logic [7:0]  core_wdata,
    input  logic        core_nread,
    input  logic        core_nwrite,
    output logic [7:0]  core_rdata,
    output logic        core_wait,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_wdata,
    output logic        bus_nread,
    output logic        bus_nwrite,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active
);

    logic       reg_hit;
    logic       core_req;
    logic       trigger;
    logic [7:0] src_hi;
    bus_req_t   dma_req;

    assign reg_hit  = core_address == DMA_REG;
    assign core_req = !core_nread || !core_nwrite;
    assign trigger  = reg_hit && !core_nwrite;

    oam_dma_seq #(
        .DMA_DEST (DMA_DEST),
        .DMA_LEN  (DMA_LEN)
    ) u_seq (
        .clock        (clock),
        .reset        (reset),
        .trigger      (trigger),
        .trigger_data (core_wdata),
        .bus_rdata    (bus_rdata),
        .dma_active   (dma_active),
        .src_hi       (src_hi),
        .dma_req      (dma_req)
    );

    // The DMA register never reaches the bus and never stalls, in any state.
    always_comb begin
        bus_address = core_address;
        bus_wdata   = core_wdata;
        bus_nread   = core_nread;
        bus_nwrite  = core_nwrite;
        core_rdata  = bus_rdata;
        core_wait   = 1'b0;
        if (dma_active) begin
            bus_address = dma_req.address;
            bus_wdata   = dma_req.wdata;
            bus_nread   = dma_req.nread;
            bus_nwrite  = dma_req.nwrite;
            core_wait   = core_req && !reg_hit;
        end else if (reg_hit) begin
            bus_nread  = 1'b1;
            bus_nwrite = 1'b1;
        end
        if (reg_hit) begin
            core_rdata = src_hi;
        end
    end

endmodule
